audio_mixer: RTL and testbench
==============================

Name: audio_mixer

Overview:
- Stereo audio mixer directly upstream of the I2S-style DAC output shifter on the board.
- Captures YM2612 FM samples (signed 14-bit, stereo) and SN76489 PSG samples (unsigned 10-bit, mono), scales them, sums them and saturates the result. An optional one-pole low-pass filter follows.
- Presents 16-bit signed ldata/rdata that change only at a frame boundary derived from the shifter's LR clock, so the shifter never latches a torn L/R pair.

Parameters:
- FM_SHIFT, 2, left shift applied to sign-extended FM samples.
- PSG_SHIFT, 3, left shift applied to the bias-removed PSG sample.
- PSG_BIAS, 512, PSG value that represents silence.
- LPF_SHIFT, 2, filter coefficient 2^-LPF_SHIFT; legal range 1..6.

Ports:
- clk  in  1  system clock, 32 MHz.
- nreset  in  1  asynchronous active-low reset.
- fm_left  in  14  FM left sample, two's complement.
- fm_right  in  14  FM right sample, two's complement.
- fm_valid  in  1  one-cycle strobe; fm_left/fm_right are captured.
- psg_sample  in  10  PSG mono sample, unsigned.
- psg_valid  in  1  one-cycle strobe; psg_sample is captured.
- fm_en  in  1  1 = include FM in the mix.
- psg_en  in  1  1 = include PSG in the mix.
- lpf_en  in  1  1 = route the mix through the low-pass filter.
- mute  in  1  1 = mix input forced to 0.
- lrck  in  1  LR clock from the output shifter (aud_daclrck), same clock domain.
- ldata  out  16  left output sample, signed.
- rdata  out  16  right output sample, signed.
- frame_tick  out  1  one-cycle pulse when ldata/rdata update.

Behaviour:
- Reset: fm_l_hold = 0, fm_r_hold = 0, psg_hold = PSG_BIAS, lrck_d = 0, all pipeline and filter state = 0, ldata = 0, rdata = 0, frame_tick = 0.
- Capture: fm_valid high → fm_l_hold/fm_r_hold load on that edge. psg_valid high → psg_hold loads. Strobes are independent; simultaneous strobes are both captured.
- Tick detect: lrck_d <= lrck every cycle; tick = lrck & ~lrck_d (rising edge).
  - The shifter loads left 128 cycles after this edge and right 256 cycles after it.
  - Updating right after the rising edge therefore always delivers a matched pair.
- Pipeline runs once per tick; stage registers are enabled by a tick-delayed shift chain.
  - S1 (tick+1), snapshot of the holds as of the tick cycle:
    - f = sign-extended fm × 2^FM_SHIFT, per channel.
    - p = (psg_hold − PSG_BIAS) × 2^PSG_SHIFT, signed.
    - Operands are zeroed when fm_en = 0 / psg_en = 0. Both are zeroed when mute = 1.
  - S2 (tick+2): sum = f + p per channel, 18-bit signed; this width cannot overflow.
  - S3 (tick+3): sat = clamp(sum, −32768, +32767).
  - S4 (tick+4):
    - lpf_en = 1: y <= y + ((sat − y) >>> LPF_SHIFT), using 18-bit intermediates and an arithmetic shift; ldata/rdata <= y.
    - lpf_en = 0: y <= sat; ldata/rdata <= sat.
    - The filter state therefore tracks the output, so toggling lpf_en never causes a jump.
    - frame_tick = 1 for this cycle only.
- Latency: tick cycle to output update is 4 clocks, far below the 127-cycle margin before the shifter's next load.
- Between updates ldata/rdata are held constant regardless of fm_valid/psg_valid activity.
- A capture coincident with a tick cycle is not in that frame's snapshot; it appears on the next tick.
- A tick arriving while the pipeline is busy cannot occur (minimum tick spacing is 256 clocks). Any tick is accepted unconditionally.
- lrck stuck at a constant: no ticks, outputs frozen.
- Reset mid-pipeline: all state returns to reset values immediately (asynchronous). The first update is produced at tick+4 after reset release.

Decomposition:
- Package audio_pkg:
  - widths FM_W = 14, PSG_W = 10, SAMPLE_W = 16, ACC_W = 18.
  - constants SAMPLE_MAX = 32767, SAMPLE_MIN = −32768.
  - a function sat16(acc) shared with future audio blocks.
- One sub-module, audio_mix_chan: holds S1–S4 for a single channel and is instantiated twice (left, right).
  - The top level owns capture, tick detection, the psg operand (shared by both channels) and the control gating.

Test Plan:
- Reset then lrck toggling, no strobes → ldata = rdata = 0 after every tick; frame_tick pulses once per 256 clocks.
- fm_left = 14'h1FFF, fm_right = 14'h2000, psg = 512, lpf_en = 0 → ldata = 32764, rdata = −32768 at tick+4.
- fm_left = 14'h1FFF, psg = 1023 → sum 32764 + 4088 clamps to ldata = 32767. psg = 0, fm_right = 14'h2000 → rdata clamps to −32768.
- fm_valid with new data at tick+10 (mid-frame) → ldata unchanged until the next tick+4. Data strobed on the tick cycle itself is used only on the following tick.
- lpf_en = 1, LPF_SHIFT = 2, step from 0 to sat = 4000 → successive outputs 1000, 1750, 2312, 2734.
- nreset asserted at tick+2 → ldata/rdata = 0 immediately; after release, the first non-zero output appears exactly 4 clocks after the next rising lrck.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio widths, sample limits and the saturating narrow-to-16-bit helper.
package audio_pkg;
  localparam int FM_W       = 14;
  localparam int PSG_W      = 10;
  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 18;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic sample_t sat16(input acc_t acc);
    if (acc > acc_t'(SAMPLE_MAX))      return sample_t'(SAMPLE_MAX);
    else if (acc < acc_t'(SAMPLE_MIN)) return sample_t'(SAMPLE_MIN);
    else                               return sample_t'(acc);
  endfunction
endpackage

// File: rtl/audio_mix_chan.sv
// One mixer channel: operand snapshot, sum, saturate, optional one-pole low-pass.
module audio_mix_chan
  import audio_pkg::*;
#(
  parameter int LPF_SHIFT = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  stg_en_i,
  input  acc_t        f_op_i,
  input  acc_t        p_op_i,
  input  logic        lpf_en_i,
  output sample_t     data_o
);
  acc_t    f_q, p_q, sum_q;
  sample_t sat_q, y_q, y_d;
  acc_t    diff, y_filt;

  // Filter state is always the last output, so switching lpf_en is glitch-free.
  always_comb begin
    diff   = acc_t'(sat_q) - acc_t'(y_q);
    y_filt = acc_t'(y_q) + (diff >>> LPF_SHIFT);
    y_d    = lpf_en_i ? sample_t'(y_filt) : sat_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      f_q   <= '0;
      p_q   <= '0;
      sum_q <= '0;
      sat_q <= '0;
      y_q   <= '0;
    end else begin
      if (stg_en_i[0]) begin
        f_q <= f_op_i;
        p_q <= p_op_i;
      end
      if (stg_en_i[1]) sum_q <= f_q + p_q;
      if (stg_en_i[2]) sat_q <= sat16(sum_q);
      if (stg_en_i[3]) y_q   <= y_d;
    end
  end

  assign data_o = y_q;
endmodule

// File: rtl/audio_mixer.sv
// FM + PSG stereo mixer; updates ldata/rdata 4 clocks after each rising lrck.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int FM_SHIFT  = 2,
  parameter int PSG_SHIFT = 3,
  parameter int PSG_BIAS  = 512,
  parameter int LPF_SHIFT = 2
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [FM_W-1:0]     fm_left,
  input  logic [FM_W-1:0]     fm_right,
  input  logic                fm_valid,
  input  logic [PSG_W-1:0]    psg_sample,
  input  logic                psg_valid,
  input  logic                fm_en,
  input  logic                psg_en,
  input  logic                lpf_en,
  input  logic                mute,
  input  logic                lrck,
  output logic [SAMPLE_W-1:0] ldata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                frame_tick
);
  logic signed [FM_W-1:0] fm_l_q, fm_r_q;
  logic [PSG_W-1:0]       psg_q;
  logic                   lrck_q, tick;
  logic [4:1]             vld_pipe;
  logic [3:0]             stg_en;
  logic                   fm_on, psg_on;
  acc_t                   f_l_op, f_r_op, p_op;
  sample_t                l_out, r_out;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fm_l_q   <= '0;
      fm_r_q   <= '0;
      psg_q    <= PSG_W'(PSG_BIAS);
      lrck_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (fm_valid) begin
        fm_l_q <= fm_left;
        fm_r_q <= fm_right;
      end
      if (psg_valid) psg_q <= psg_sample;
      lrck_q   <= lrck;
      vld_pipe <= {vld_pipe[3:1], tick};
    end
  end

  assign tick   = lrck & ~lrck_q;
  assign stg_en = {vld_pipe[3:1], tick};

  // Operands come from the holds as they stand in the tick cycle; a same-cycle capture lands next frame.
  assign fm_on  = fm_en  & ~mute;
  assign psg_on = psg_en & ~mute;
  assign f_l_op = fm_on  ? (acc_t'(fm_l_q) <<< FM_SHIFT) : '0;
  assign f_r_op = fm_on  ? (acc_t'(fm_r_q) <<< FM_SHIFT) : '0;
  assign p_op   = psg_on ? ((acc_t'({1'b0, psg_q}) - acc_t'(PSG_BIAS)) <<< PSG_SHIFT) : '0;

  audio_mix_chan #(.LPF_SHIFT(LPF_SHIFT)) u_chan_l (
    .clk(clk), .nreset(nreset), .stg_en_i(stg_en),
    .f_op_i(f_l_op), .p_op_i(p_op), .lpf_en_i(lpf_en), .data_o(l_out)
  );

  audio_mix_chan #(.LPF_SHIFT(LPF_SHIFT)) u_chan_r (
    .clk(clk), .nreset(nreset), .stg_en_i(stg_en),
    .f_op_i(f_r_op), .p_op_i(p_op), .lpf_en_i(lpf_en), .data_o(r_out)
  );

  assign ldata      = l_out;
  assign rdata      = r_out;
  assign frame_tick = vld_pipe[4];
endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: lrck period 256 clocks, outputs checked around tick+4.
module tb_audio_mixer;
  logic        clk = 1'b0;
  logic        nreset;
  logic [13:0] fm_left, fm_right;
  logic        fm_valid;
  logic [9:0]  psg_sample;
  logic        psg_valid;
  logic        fm_en, psg_en, lpf_en, mute, lrck;
  logic [15:0] ldata, rdata;
  logic        frame_tick;

  int n_chk = 0;
  int n_err = 0;
  int pos;
  bit stuck;

  audio_mixer dut (
    .clk(clk), .nreset(nreset),
    .fm_left(fm_left), .fm_right(fm_right), .fm_valid(fm_valid),
    .psg_sample(psg_sample), .psg_valid(psg_valid),
    .fm_en(fm_en), .psg_en(psg_en), .lpf_en(lpf_en), .mute(mute),
    .lrck(lrck), .ldata(ldata), .rdata(rdata), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pos counts clocks since the last rising lrck; lrck is high for pos 0..127.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (!stuck) begin
        pos++;
        if (pos == 128) lrck = 1'b0;
        if (pos == 256) begin lrck = 1'b1; pos = 0; end
      end
    end
  endtask

  task automatic to_tick();
    int guard = 0;
    do begin
      adv(1);
      guard++;
    end while (pos != 0 && guard < 300);
    if (pos != 0) chk("tick_timeout", pos, 0);
  endtask

  task automatic out_chk(input string tag, input int l, input int r);
    chk({tag, "_L"}, int'($signed(ldata)), l);
    chk({tag, "_R"}, int'($signed(rdata)), r);
  endtask

  task automatic frame_chk(input string tag, input int l, input int r);
    to_tick();
    adv(3);
    chk({tag, "_ft_pre"}, int'(frame_tick), 0);
    adv(1);
    chk({tag, "_ft"}, int'(frame_tick), 1);
    out_chk(tag, l, r);
    adv(1);
    chk({tag, "_ft_post"}, int'(frame_tick), 0);
  endtask

  task automatic strobe_fm(input int l, input int r);
    fm_left = 14'(l); fm_right = 14'(r); fm_valid = 1'b1;
    adv(1);
    fm_valid = 1'b0;
  endtask

  task automatic strobe_psg(input int p);
    psg_sample = 10'(p); psg_valid = 1'b1;
    adv(1);
    psg_valid = 1'b0;
  endtask

  initial begin
    int ft_cnt;
    nreset = 1'b0; lrck = 1'b0; stuck = 1'b0; pos = 200;
    fm_left = '0; fm_right = '0; fm_valid = 1'b0;
    psg_sample = '0; psg_valid = 1'b0;
    fm_en = 1'b1; psg_en = 1'b1; lpf_en = 1'b0; mute = 1'b0;
    #1;
    out_chk("reset", 0, 0);
    chk("reset_ft", int'(frame_tick), 0);
    adv(3);
    nreset = 1'b1;

    frame_chk("idle0", 0, 0);
    frame_chk("idle1", 0, 0);

    adv(5); strobe_fm(8191, -8192);
    frame_chk("fullscale", 32764, -32768);
    strobe_psg(1023);
    frame_chk("clip_hi", 32767, -28680);
    strobe_psg(0);
    frame_chk("clip_lo", 28668, -32768);

    strobe_fm(1000, -1000); strobe_psg(512); mute = 1'b1;
    frame_chk("mute", 0, 0);
    mute = 1'b0; lpf_en = 1'b1;
    frame_chk("lpf1", 1000, -1000);
    frame_chk("lpf2", 1750, -1750);
    frame_chk("lpf3", 2312, -2313);
    frame_chk("lpf4", 2734, -2735);
    lpf_en = 1'b0;
    frame_chk("lpf_off", 4000, -4000);

    strobe_psg(1023); fm_en = 1'b0;
    frame_chk("fm_off", 4088, 4088);
    fm_en = 1'b1; psg_en = 1'b0;
    frame_chk("psg_off", 4000, -4000);
    psg_en = 1'b1;
    frame_chk("both", 8088, 88);
    strobe_psg(512);

    // capture on the tick cycle itself belongs to the following frame
    to_tick();
    strobe_fm(2000, -2000);
    adv(3);
    out_chk("coinc_old", 4000, -4000);
    frame_chk("coinc_new", 8000, -8000);

    adv(4); strobe_fm(3000, -3000);
    adv(90);  out_chk("mid_hold100", 8000, -8000);
    adv(155); out_chk("mid_hold255", 8000, -8000);
    frame_chk("mid_new", 12000, -12000);

    to_tick(); adv(2);
    nreset = 1'b0; #1;
    out_chk("rst_async", 0, 0);
    chk("rst_ft", int'(frame_tick), 0);
    adv(148);
    nreset = 1'b1;
    strobe_fm(100, -100);
    to_tick(); adv(3);
    out_chk("rst_pre", 0, 0);
    adv(1);
    out_chk("rst_first", 400, -400);

    stuck = 1'b1; lrck = 1'b0; ft_cnt = 0;
    repeat (600) begin
      adv(1);
      ft_cnt += int'(frame_tick);
    end
    chk("stuck_ticks", ft_cnt, 0);
    out_chk("stuck_hold", 400, -400);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
